// File: rtl/alu_nibble_sequencer.sv
// Multi-cycle controller that drives an external 4-bit ALU one nibble per cycle,
// LS nibble first, rippling the carry through an internal register.
module alu_nibble_sequencer #(
   parameter  int NIBBLES = 4,
   localparam int WIDTH   = 4 * NIBBLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [2:0]       alu_sel,
   output logic             alu_cin,
   input  logic [3:0]       alu_out,
   input  logic             alu_cout
);

   localparam logic [2:0] SEL_ADD  = 3'b011;
   localparam logic [2:0] SEL_XOR  = 3'b100;
   localparam logic [2:0] SEL_PASS = 3'b111;

   localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2:0]         op_q;
   logic               carry_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic [WIDTH-1:0]   result_q;
   logic               cout_q;

   function automatic logic op_legal(input logic [2:0] sel);
      return (sel == SEL_ADD) || (sel == SEL_XOR) || (sel == SEL_PASS);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= SEL_PASS;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (op_legal(op)) begin
                     a_q     <= opa;
                     b_q     <= opb;
                     op_q    <= op;
                     carry_q <= (op == SEL_ADD) ? cin : 1'b0;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               result_q[4*idx_q +: 4] <= alu_out;
               carry_q                <= (op_q == SEL_ADD) ? alu_cout : 1'b0;
               idx_q                  <= idx_q + IDX_W'(1);
               // The carry leaving the last nibble is registered straight into cout,
               // so done and cout appear together in FIN.
               if (idx_q == IDX_LAST) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cout_q  <= (op_q == SEL_ADD) ? alu_cout : 1'b0;
                  state_q <= FIN;
               end
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outside RUN the ALU sees a benign pass of zero so its outputs never go x.
   assign alu_a   = (state_q == RUN) ? a_q[4*idx_q +: 4] : 4'h0;
   assign alu_b   = (state_q == RUN) ? b_q[4*idx_q +: 4] : 4'h0;
   assign alu_sel = (state_q == RUN) ? op_q : SEL_PASS;
   assign alu_cin = (state_q == RUN) ? carry_q : 1'b0;

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;
   assign cout   = cout_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer (NIBBLES=4) with a behavioural 4-bit ALU.
module tb_alu_nibble_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [15:0] opa;
   logic [15:0] opb;
   logic        cin;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] result;
   logic        cout;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [2:0]  alu_sel;
   logic        alu_cin;
   logic [3:0]  alu_out;
   logic        alu_cout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [15:0] res;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   alu_nibble_sequencer #(.NIBBLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .opa      (opa),
      .opb      (opb),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .result   (result),
      .cout     (cout),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_sel  (alu_sel),
      .alu_cin  (alu_cin),
      .alu_out  (alu_out),
      .alu_cout (alu_cout)
   );

   // Stand-in for the external ALU: its carry output is always the adder carry,
   // whatever the select, so the sequencer has to mask it for xor and pass.
   logic [4:0] alu_sum;
   always_comb begin
      alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      alu_out  = 4'h0;
      case (alu_sel)
         3'b011:  alu_out = alu_sum[3:0];
         3'b100:  alu_out = alu_a ^ alu_b;
         3'b111:  alu_out = alu_a;
         default: alu_out = 4'h0;
      endcase
      alu_cout = alu_sum[4];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [15:0] a,
                                  input logic [15:0] b, input logic c);
      exp_t       e;
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b} + {16'b0, c};
      e.cyc = 0;
      case (o)
         3'b011:  begin e.res = s[15:0]; e.c = s[16]; end
         3'b100:  begin e.res = a ^ b;   e.c = 1'b0;  end
         default: begin e.res = a;       e.c = 1'b0;  end
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", {16'b0, result}, {16'b0, e.res});
            chk("cout", {31'b0, cout}, {31'b0, e.c});
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Called just after a rising edge with the DUT in IDLE; returns likewise.
   task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input bit poke);
      exp_t e;
      start = 1'b1; op = o; opa = a; opb = b; cin = c;
      @(posedge clk); #1;
      start = 1'b0;
      e     = model(o, a, b, c);
      e.cyc = cyc + 4;
      sb.push_back(e);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("busy_run", {31'b0, busy}, 32'd1);
         opa = 16'($urandom);
         opb = 16'($urandom);
         cin = 1'($urandom);
         op  = 3'b011;
         start = (poke && i == 1);
      end
      @(negedge clk);
      chk("busy_fin", {31'b0, busy}, 32'd0);
      start = poke;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   logic [15:0] held;

   initial begin
      start = 1'b0; op = 3'b000; opa = '0; opb = '0; cin = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_result", {16'b0, result}, 32'd0);
      chk("rst_cout", {31'b0, cout}, 32'd0);
      chk("rst_alu_sel", {29'b0, alu_sel}, 32'd7);
      chk("rst_alu_a", {28'b0, alu_a}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(3'b011, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      issue(3'b011, 16'h0FFF, 16'h0000, 1'b1, 1'b0);
      issue(3'b100, 16'hA5A5, 16'h0FF0, 1'b1, 1'b0);
      issue(3'b111, 16'h1234, 16'hFFFF, 1'b0, 1'b0);
      chk("idle_alu_sel", {29'b0, alu_sel}, 32'd7);
      chk("idle_alu_cin", {31'b0, alu_cin}, 32'd0);

      held  = result;
      start = 1'b1; op = 3'b000; opa = 16'h5555; opb = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("err_pulse", {31'b0, err}, 32'd1);
      chk("err_busy", {31'b0, busy}, 32'd0);
      chk("err_result", {16'b0, result}, {16'b0, held});
      @(negedge clk);
      chk("err_clear", {31'b0, err}, 32'd0);
      chk("err_busy2", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;

      issue(3'b011, 16'h8001, 16'h7FFF, 1'b0, 1'b1);
      chk("poke_err", {31'b0, err}, 32'd0);

      for (int n = 0; n < 6; n++) begin
         logic [2:0] o;
         case (n % 3)
            0:       o = 3'b011;
            1:       o = 3'b100;
            default: o = 3'b111;
         endcase
         issue(o, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      end

      start = 1'b1; op = 3'b011; opa = 16'hFFFF; opb = 16'h0001; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_err", {31'b0, err}, 32'd0);
      chk("abort_result", {16'b0, result}, 32'd0);
      chk("abort_cout", {31'b0, cout}, 32'd0);
      chk("abort_alu_sel", {29'b0, alu_sel}, 32'd7);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      issue(3'b011, 16'h0001, 16'h0001, 1'b0, 1'b0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
